// File: rtl/fft_power_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fft_power_pkg
// Description : Shared constants and types for the FFT power-spectrum stage.
//               Default widths, derived frame constants and the frame
//               alignment state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package fft_power_pkg;

    localparam int c_iwidth     = 21;               // signed re/im component width
    localparam int c_owidth     = 32;               // unsigned power word width
    localparam int c_lgnfft     = 8;                // log2 of FFT size
    localparam int c_shift      = 10;               // right shift of the power sum
    localparam int c_nfft       = 1 << c_lgnfft;    // 256-point FFT
    localparam int c_nbins_kept = c_nfft / 2 + 1;   // bins 0..NFFT/2
    localparam int c_pwidth     = 2 * c_iwidth;     // width of one square

    typedef enum logic [0:0] {
        WAIT_SYNC = 1'b0,
        ACTIVE    = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/fft_cplx_sq.sv
`default_nettype none
// ============================================================================
// Module      : fft_cplx_sq
// Description : Two-stage, i_ce-gated |x|^2 pipeline with a tag side-channel.
//               Stage 1 registers re^2 and im^2, stage 2 sums, shifts and
//               reduces to OWIDTH bits.
//               Config macro FFT_POWER_SAT_EN: saturate instead of wrap when
//               the shifted sum does not fit in OWIDTH bits.
// Ports       : i_clk, i_reset_n (async, active-low), i_ce (advance)
//               i_re/i_im   signed components
//               i_keep/i_first/i_last  tags travelling with the sample
//               o_power/o_valid/o_first/o_last  registered result
// Revision    : 1.0 - initial release
// ============================================================================
module fft_cplx_sq
    import fft_power_pkg::*;
#(
    parameter int IWIDTH = c_iwidth,
    parameter int OWIDTH = c_owidth,
    parameter int SHIFT  = c_shift
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic                     i_ce,
    input  logic signed [IWIDTH-1:0] i_re,
    input  logic signed [IWIDTH-1:0] i_im,
    input  logic                     i_keep,
    input  logic                     i_first,
    input  logic                     i_last,
    output logic        [OWIDTH-1:0] o_power,
    output logic                     o_valid,
    output logic                     o_first,
    output logic                     o_last
);

    localparam int c_pw = 2 * IWIDTH;

    // Sign-extend to the full product width so (-2^(IWIDTH-1))^2 is exact.
    logic signed [c_pw-1:0] w_re_ext;
    logic signed [c_pw-1:0] w_im_ext;
    logic        [c_pw:0]   w_sum;
    logic        [c_pw:0]   w_shifted;
    logic     [OWIDTH-1:0]  w_power;

    logic [c_pw-1:0]   re_sq_q, re_sq_d;
    logic [c_pw-1:0]   im_sq_q, im_sq_d;
    logic              keep1_q, keep1_d;
    logic              first1_q, first1_d;
    logic              last1_q, last1_d;
    logic [OWIDTH-1:0] power_q, power_d;
    logic              valid_q, valid_d;
    logic              first_q, first_d;
    logic              last_q, last_d;

    assign w_re_ext  = {{IWIDTH{i_re[IWIDTH-1]}}, i_re};
    assign w_im_ext  = {{IWIDTH{i_im[IWIDTH-1]}}, i_im};
    assign w_sum     = {1'b0, re_sq_q} + {1'b0, im_sq_q};
    assign w_shifted = w_sum >> SHIFT;

`ifdef FFT_POWER_SAT_EN
    logic w_over;
    // Any bit at or above OWIDTH means the value does not fit.
    assign w_over  = |(w_shifted >> OWIDTH);
    assign w_power = w_over ? {OWIDTH{1'b1}} : OWIDTH'(w_shifted);
`else
    assign w_power = OWIDTH'(w_shifted);
`endif

    always_comb begin
        re_sq_d  = re_sq_q;
        im_sq_d  = im_sq_q;
        keep1_d  = keep1_q;
        first1_d = first1_q;
        last1_d  = last1_q;
        power_d  = power_q;
        first_d  = first_q;
        last_d   = last_q;
        // Valid is a strobe: it only survives an edge that loads a kept bin.
        valid_d  = i_ce & keep1_q;
        if (i_ce) begin
            re_sq_d  = w_re_ext * w_re_ext;
            im_sq_d  = w_im_ext * w_im_ext;
            keep1_d  = i_keep;
            first1_d = i_first;
            last1_d  = i_last;
            power_d  = w_power;
            first_d  = first1_q;
            last_d   = last1_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            re_sq_q  <= '0;
            im_sq_q  <= '0;
            keep1_q  <= 1'b0;
            first1_q <= 1'b0;
            last1_q  <= 1'b0;
            power_q  <= '0;
            valid_q  <= 1'b0;
            first_q  <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            re_sq_q  <= re_sq_d;
            im_sq_q  <= im_sq_d;
            keep1_q  <= keep1_d;
            first1_q <= first1_d;
            last1_q  <= last1_d;
            power_q  <= power_d;
            valid_q  <= valid_d;
            first_q  <= first_d;
            last_q   <= last_d;
        end
    end

    assign o_power = power_q;
    assign o_valid = valid_q;
    assign o_first = first_q;
    assign o_last  = last_q;

endmodule
`default_nettype wire

// File: rtl/fft_power.sv
`default_nettype none
// ============================================================================
// Module      : fft_power
// Description : Streaming power-spectrum stage behind the 256-point FFT.
//               Tracks frame alignment from i_sync, keeps bins 0..NFFT/2,
//               computes (re^2+im^2) >> SHIFT and tags first/last bins.
//               Config macro FFT_POWER_SAT_EN: saturating output (see
//               fft_cplx_sq); default build wraps.
// Ports       : i_clk, i_reset_n (async, active-low), i_ce (one bin/strobe)
//               i_sample {re, im} two's complement, i_sync (bin 0 marker)
//               o_power, o_valid, o_first (bin 0), o_last (bin NFFT/2)
//               o_sync_err  one-cycle pulse on frame misalignment
// Revision    : 1.0 - initial release
// ============================================================================
module fft_power
    import fft_power_pkg::*;
#(
    parameter int IWIDTH = c_iwidth,
    parameter int OWIDTH = c_owidth,
    parameter int LGNFFT = c_lgnfft,
    parameter int SHIFT  = c_shift
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_ce,
    input  logic [2*IWIDTH-1:0]   i_sample,
    input  logic                  i_sync,
    output logic [OWIDTH-1:0]     o_power,
    output logic                  o_valid,
    output logic                  o_first,
    output logic                  o_last,
    output logic                  o_sync_err
);

    localparam logic [LGNFFT-1:0] c_half = LGNFFT'(1 << (LGNFFT - 1));
    localparam logic [LGNFFT-1:0] c_one  = LGNFFT'(1);

    state_t              state_q, state_d;
    // bin_q holds the index the next ACTIVE sample is expected to carry.
    logic [LGNFFT-1:0]   bin_q, bin_d;
    logic                sync_err_q, sync_err_d;
    logic                w_keep;
    logic                w_first;
    logic                w_last;
    logic signed [IWIDTH-1:0] w_re;
    logic signed [IWIDTH-1:0] w_im;

    assign w_re = i_sample[2*IWIDTH-1:IWIDTH];
    assign w_im = i_sample[IWIDTH-1:0];

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        sync_err_d = 1'b0;
        w_keep     = 1'b0;
        w_first    = 1'b0;
        w_last     = 1'b0;
        if (i_ce) begin
            case (state_q)
                WAIT_SYNC: begin
                    if (i_sync) begin
                        state_d = ACTIVE;
                        bin_d   = c_one;
                        w_keep  = 1'b1;
                        w_first = 1'b1;
                    end
                end
                ACTIVE: begin
                    if (i_sync) begin
                        // Sync always restarts the frame; it is only an
                        // error when it arrives before the counter wrapped.
                        sync_err_d = (bin_q != '0);
                        bin_d      = c_one;
                        w_keep     = 1'b1;
                        w_first    = 1'b1;
                    end else if (bin_q == '0) begin
                        // Counter wrapped but the FFT sent no sync: realign.
                        sync_err_d = 1'b1;
                        state_d    = WAIT_SYNC;
                    end else begin
                        w_keep = (bin_q <= c_half);
                        w_last = (bin_q == c_half);
                        bin_d  = bin_q + c_one;
                    end
                end
                default: state_d = WAIT_SYNC;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= WAIT_SYNC;
            bin_q      <= '0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            sync_err_q <= sync_err_d;
        end
    end

    fft_cplx_sq #(
        .IWIDTH (IWIDTH),
        .OWIDTH (OWIDTH),
        .SHIFT  (SHIFT)
    ) u_sq (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_ce      (i_ce),
        .i_re      (w_re),
        .i_im      (w_im),
        .i_keep    (w_keep),
        .i_first   (w_first),
        .i_last    (w_last),
        .o_power   (o_power),
        .o_valid   (o_valid),
        .o_first   (o_first),
        .o_last    (o_last)
    );

    assign o_sync_err = sync_err_q;

endmodule
`default_nettype wire
